instr_decode_stage: RTL
=======================

# instr_decode_stage

- Parametrised, elastic instruction-decode pipeline stage for the CPU datapath.
- Position in the design:
  - Accepts fetched instruction words from IF over a valid/ready handshake.
  - Splits each word into opcode and immediate fields.
  - Extends the immediate to datapath width.
  - Flags HALT and, optionally, illegal opcodes.
  - Presents one registered decoded entry to EX.
- A 2-entry skid buffer gives full throughput with registered `in_ready`; `halt_program` and `flush` give pipeline control.

## Interface
Parameters:
- `INSTR_W`, 16, instruction word width.
- `OPC_W`, 8, opcode width; opcode = `instr[INSTR_W-1 -: OPC_W]`.
- `IMM_W`, `INSTR_W-OPC_W`, raw immediate width; immediate = `instr[IMM_W-1:0]`.
- `DATA_W`, 16, extended immediate width; must be ≥ `IMM_W`.
- `NUM_OPS`, 32, count of legal opcodes (0..NUM_OPS-1).
- `HALT_OP`, 8'hFF, opcode value of the HALT instruction.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `halt_program` in 1: freeze; all state holds while high.
- `flush` in 1: discard all buffered entries and clear halt latch.
- `in_valid` in 1: IF offers `in_instr`.
- `in_ready` out 1: stage can accept; registered.
- `in_instr` in `INSTR_W`: instruction word.
- `out_valid` out 1: decoded entry present.
- `out_ready` in 1: EX consumes entry.
- `out_opcode` out `OPC_W`: decoded opcode.
- `out_imm` out `IMM_W`: raw immediate.
- `out_imm_ext` out `DATA_W`: extended immediate.
- `out_is_halt` out 1: entry opcode == `HALT_OP`.
- `out_illegal` out 1: entry opcode ≥ `NUM_OPS`.
- `illegal_count` out 8: saturating count of illegal entries accepted.

## Operation
- Transfers:
  - Input transfer: `in_valid && in_ready && !halt_program`.
  - Output transfer: `out_valid && out_ready && !halt_program`.
- Decode is combinational on `in_instr`. Fields are stored at input transfer:
  - `out_opcode`
  - `out_imm`
  - `out_imm_ext`
  - `out_is_halt`
  - `out_illegal`
- Extension rule: `opcode[OPC_W-1]==1` selects sign-extension of `out_imm` to `DATA_W`; otherwise zero-extension.
- Storage is a main register (drives outputs) plus a skid register.
- States, as (main_v, skid_v):
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
- Transitions, with in = input transfer and out = output transfer:
  - EMPTY + in → ONE.
  - ONE + in & !out → FULL; the new word goes to skid.
  - ONE + in & out → ONE; main is replaced.
  - ONE + out & !in → EMPTY.
  - FULL + out → ONE; skid moves to main.
- `in_ready` is the registered value of `!skid_v && !halt_latched`.
- Halt latch:
  - Set at input transfer of a word whose opcode == `HALT_OP`.
  - While set, `in_ready`=0; buffered entries still drain.
  - Cleared only by `flush` or `rst`.
- `flush`:
  - Next cycle main_v=skid_v=0 and halt_latched=0.
  - An input transfer in the same cycle is discarded.
  - Wins over `halt_program`.
  - `illegal_count` is not cleared.
- `halt_program`:
  - No transfers; all registers hold.
  - `out_valid` holds its value, but EX must not consume while halted.
- Priority: `rst` > `flush` > `halt_program` > handshake.
- Reset values:
  - `out_valid`=0, `in_ready`=0 (becomes 1 the cycle after `rst` deasserts).
  - `out_opcode`=0, `out_imm`=0, `out_imm_ext`=0.
  - `out_is_halt`=0, `out_illegal`=0, `illegal_count`=0, halt_latched=0.

## Timing
- Latency: 1 cycle. A word accepted at edge N is at the outputs with `out_valid`=1 after edge N.
- Throughput: 1 word/cycle while `out_ready`=1.
- Backpressure:
  - With `out_ready` low, the stage absorbs at most 2 words.
  - `in_ready` falls the cycle after the skid register fills.
- Outputs are stable while `out_valid && !out_ready`.
- `illegal_count`:
  - Increments at the input transfer edge.
  - Saturates at 255; no wrap.

## Configuration
- Macro: `DECODE_ILLEGAL_CHECK_EN`.
- Defined:
  - `out_illegal` is computed as opcode ≥ `NUM_OPS`.
  - `illegal_count` is active.
- Undefined:
  - `out_illegal` is tied 0 and `illegal_count` is tied 0.
  - Illegal opcodes pass as normal entries.
  - No comparator or counter is synthesised.

## Test plan
- Reset: hold `rst` 2 cycles.
  - During reset: all outputs 0.
  - `in_ready`=1 on the first cycle after release.
- Stream, `out_ready`=1, instructions 16'h0305, 16'h8AF0, 16'h1000 on consecutive cycles:
  - One entry per cycle, 1-cycle latency.
  - Outputs (opcode, `out_imm_ext`): (8'h03, 16'h0005), (8'h8A, 16'hFFF0), (8'h10, 16'h0000).
- Backpressure: `out_ready`=0, offer 3 words.
  - Exactly 2 are accepted; `in_ready`=0 after the second.
  - Raising `out_ready` drains them in order, then the third is accepted.
- HALT: send 16'hFF00 then 16'h0101.
  - `out_is_halt`=1 on the first entry.
  - Second word is not accepted until `flush`; after `flush` it is accepted.
- `halt_program` asserted 3 cycles during FULL with `out_ready`=1:
  - No transfers and registers unchanged.
  - Draining resumes the cycle after deassertion.
  - `flush` during halt empties the buffers.
- With `DECODE_ILLEGAL_CHECK_EN`:
  - Opcode 8'h20 (`NUM_OPS`=32) gives `out_illegal`=1 and `illegal_count`=1.
  - 300 illegal words give `illegal_count`=255.
  - Without the macro: `out_illegal`=0 and count 0.

Source files
------------

// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-entry bus of the instruction-decode stage.
// The slave modport is the stage's view; master is the IF/EX environment's view.
interface instr_decode_stage_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OPC_W   = 8,
  parameter int unsigned IMM_W   = INSTR_W - OPC_W,
  parameter int unsigned DATA_W  = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [IMM_W-1:0]   out_imm;
  logic [DATA_W-1:0]  out_imm_ext;
  logic               out_is_halt;
  logic               out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_imm, out_imm_ext,
           out_is_halt, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_imm, out_imm_ext,
           out_is_halt, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Elastic decode stage: opcode/immediate split, immediate extension, HALT latch, 2-entry skid buffer.
// Optional DECODE_ILLEGAL_CHECK_EN enables the illegal-opcode flag and its saturating counter.
module instr_decode_stage #(
  parameter int unsigned      INSTR_W = 16,
  parameter int unsigned      OPC_W   = 8,
  parameter int unsigned      IMM_W   = INSTR_W - OPC_W,
  parameter int unsigned      DATA_W  = 16,
  parameter int unsigned      NUM_OPS = 32,
  parameter logic [OPC_W-1:0] HALT_OP = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt_program,
  input  logic                 flush,
  instr_decode_stage_if.slave  bus,
  output logic [7:0]           illegal_count
);

  if (DATA_W < IMM_W || NUM_OPS == 0) begin : g_bad_cfg
    $error("instr_decode_stage: DATA_W must be >= IMM_W and NUM_OPS must be nonzero");
  end

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;
    logic              is_halt;
    logic              illegal;
  } entry_t;

  // Encoding is {skid_v, main_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e state_q, state_n;
  entry_t main_q, main_n;
  entry_t skid_q, skid_n;
  entry_t dec;
  logic   halt_q, halt_n;
  logic   in_ready_q, in_ready_n;
  logic   xfer_in, xfer_out;
  logic   sext;

  assign xfer_in  = bus.in_valid && in_ready_q && !halt_program;
  assign xfer_out = (state_q != EMPTY) && bus.out_ready && !halt_program;

  // Sign-extension is selected by the opcode MSB, not by the immediate itself.
  always_comb begin
    dec        = '0;
    dec.opcode = bus.in_instr[INSTR_W-1 -: OPC_W];
    dec.imm    = bus.in_instr[IMM_W-1:0];
    sext       = dec.opcode[OPC_W-1] & dec.imm[IMM_W-1];
    dec.imm_ext = {DATA_W{sext}};
    dec.imm_ext[IMM_W-1:0] = dec.imm;
    dec.is_halt = (dec.opcode == HALT_OP);
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = (32'(dec.opcode) >= NUM_OPS);
`else
    dec.illegal = 1'b0;
`endif
  end

  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    halt_n  = halt_q;
    if (flush) begin
      state_n = EMPTY;
      halt_n  = 1'b0;
    end else begin
      if (xfer_in && dec.is_halt) halt_n = 1'b1;
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_n = ONE;
            main_n  = dec;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_n = dec;
          end else if (xfer_in) begin
            state_n = FULL;
            skid_n  = dec;
          end else if (xfer_out) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state_n = ONE;
            main_n  = skid_q;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
    // Ready is derived from next-state so it drops on the same edge that fills the skid slot.
    in_ready_n = (state_n != FULL) && !halt_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      halt_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      main_q     <= main_n;
      skid_q     <= skid_n;
      halt_q     <= halt_n;
      in_ready_q <= in_ready_n;
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (!flush && xfer_in && dec.illegal && illegal_count != 8'hFF) begin
      illegal_count <= illegal_count + 8'd1;
    end
  end
`else
  assign illegal_count = '0;
`endif

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_imm_ext = main_q.imm_ext;
  assign bus.out_is_halt = main_q.is_halt;
  assign bus.out_illegal = main_q.illegal;

endmodule
